spi_bist_checker: RTL and testbench
===================================

# spi_bist_checker

Run controller and result collector for the SPI loopback self-test, sitting directly downstream of the SPI BIST datapath. It enables BIST pattern mode for a programmed number of SPI frames and samples the per-frame MOSI/MISO compare results. It counts mismatches, records the first failing frame and compacts every received MOSI byte into an 8-bit MISR signature. Software or a top-level sequencer reads a single pass/fail verdict plus diagnostics.

## Interface
- CNT_W, 16, width of frame and error counters
- WARMUP_FRAMES, 1, frames run before results are scored; covers compare-pipeline lag
- MISR_SEED, 8'hFF, signature value after reset and at each run start

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low; 0 on a rising clk edge resets the block
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE
- abort  in  1  stops a run; takes priority over every other input except reset
- num_frames  in  CNT_W  number of scored frames, sampled on the accepted start
- frame_done  in  1  one-cycle pulse per completed SPI frame; the compare results are valid in this cycle
- mosi_res  in  1  1 = MOSI compare match for the frame
- miso_res  in  1  1 = MISO compare match for the frame
- rx_byte  in  8  MOSI byte received by the slave, valid with frame_done
- bist_select  out  1  1 = datapath uses LFSR patterns
- busy  out  1  run in progress (WARMUP or RUN)
- done  out  1  run completed normally; held until the next accepted start
- pass  out  1  valid while done; 1 = both error counts are zero
- frame_cnt  out  CNT_W  scored frames completed
- mosi_err_cnt  out  CNT_W  MOSI mismatches, saturating
- miso_err_cnt  out  CNT_W  MISO mismatches, saturating
- fail_valid  out  1  first_fail holds a valid value
- first_fail  out  CNT_W  frame_cnt value of the first frame with any mismatch
- signature  out  8  MISR value

## Operation
- States: IDLE, WARMUP, RUN, DONE.
- **IDLE / DONE:**
  - An accepted start clears frame_cnt, both error counts, fail_valid and first_fail, and loads signature with MISR_SEED.
  - It also latches num_frames.
  - Next state is WARMUP if WARMUP_FRAMES > 0, otherwise RUN.
  - If the latched num_frames is 0, the block enters DONE directly with pass = 1.
- **WARMUP:**
  - Counts frame_done pulses.
  - Results and rx_byte are ignored.
  - After WARMUP_FRAMES pulses, the block moves to RUN.
- **RUN, on each frame_done:**
  - Increment frame_cnt.
  - If !mosi_res, increment mosi_err_cnt. If !miso_res, increment miso_err_cnt. Counters saturate at all-ones.
  - On the first frame with any mismatch, set fail_valid and set first_fail to the pre-increment frame_cnt.
  - Update the MISR: signature <= {signature[6:0], signature[7]^signature[5]^signature[4]^signature[3]} ^ rx_byte.
  - When the incremented frame_cnt equals the latched num_frames, go to DONE.
- **DONE:**
  - done = 1.
  - pass = (mosi_err_cnt == 0 && miso_err_cnt == 0).
  - All diagnostics are frozen.
- bist_select = 1 in WARMUP and RUN, 0 otherwise. busy follows the same rule.
- **abort:**
  - From any state, the block goes to IDLE and done is cleared.
  - Counters, first_fail and signature are retained for debug.
- start while busy is ignored.
- start and abort in the same cycle: abort wins.
- frame_done while in IDLE or DONE is ignored.

## Timing
- All outputs are registered.
- **Reset values:**
  - state IDLE.
  - bist_select, busy, done, pass and fail_valid all 0.
  - All counters and first_fail 0.
  - signature = MISR_SEED.
- **start, accepted in cycle t:**
  - busy and bist_select are 1 from cycle t+1.
  - With num_frames = 0, done = 1 and pass = 1 from cycle t+1 instead.
- **frame_done in cycle t:**
  - Counters, signature and fail fields are updated at t+1.
  - The final frame sets done and pass at t+1, and busy and bist_select drop at t+1.
- A frame_done coincident with the accepted start is ignored.
- frame_done pulses are at least 2 cycles apart (the SPI frame period is 10 clk); no back-to-back handling is required.
- Reset asserted mid-run: the block is back in IDLE with reset values on the next edge. No partial result is reported.

## Structure
- A shared package holds:
  - the state enum (IDLE, WARMUP, RUN, DONE);
  - the MISR tap constant, 8'b1011_1000 (bits 7, 5, 4, 3), identical to the LFSR feedback taps.
- One sub-module, spi_bist_misr:
  - 8-bit MISR with load-seed, enable, data input and signature output.
  - Reusable for compacting MISO-side data.
- The FSM, counters and first-fail capture live in the top module.

## Test plan
- Reset low for 2 cycles, then high -> all outputs at their reset values and signature = 8'hFF.
- start with num_frames = 4 and WARMUP_FRAMES = 1; 5 frame_done pulses all matching, rx_byte = 8'h00 -> done = 1 one cycle after the 5th pulse, pass = 1, frame_cnt = 4, errors 0, bist_select low; signature equals a golden MISR model fed four zero bytes from seed 8'hFF.
- num_frames = 6, with miso_res = 0 on scored frames 2 and 4 (0-based) -> miso_err_cnt = 2, mosi_err_cnt = 0, fail_valid = 1, first_fail = 2, pass = 0.
- num_frames = 0 -> done = 1 and pass = 1 in the cycle after start; bist_select never asserts.
- abort after 2 scored frames -> IDLE next cycle, done = 0, frame_cnt = 2 retained; a new start clears frame_cnt to 0 and reseeds signature.
- start asserted mid-run, and start plus abort together -> start is ignored while busy; abort wins and the block goes to IDLE.

Source files
------------

// File: rtl/spi_bist_checker_pkg.sv
// Shared types and constants for the SPI loopback BIST run controller and its MISR.
package spi_bist_checker_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWarmup,
    StRun,
    StDone
  } state_e;

  // Same feedback taps as the pattern LFSR (bits 7, 5, 4, 3).
  localparam logic [7:0] MisrTaps = 8'b1011_1000;

endpackage

// File: rtl/spi_bist_checker_if.sv
// Control, per-frame result and diagnostic signals between a BIST sequencer and the checker.
interface spi_bist_checker_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] num_frames;
  logic             frame_done;
  logic             mosi_res;
  logic             miso_res;
  logic [7:0]       rx_byte;
  logic             bist_select;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] mosi_err_cnt;
  logic [CNT_W-1:0] miso_err_cnt;
  logic             fail_valid;
  logic [CNT_W-1:0] first_fail;
  logic [7:0]       signature;

  modport master (
    output start, abort, num_frames, frame_done, mosi_res, miso_res, rx_byte,
    input  bist_select, busy, done, pass, frame_cnt, mosi_err_cnt, miso_err_cnt,
    input  fail_valid, first_fail, signature
  );

  modport slave (
    input  start, abort, num_frames, frame_done, mosi_res, miso_res, rx_byte,
    output bist_select, busy, done, pass, frame_cnt, mosi_err_cnt, miso_err_cnt,
    output fail_valid, first_fail, signature
  );
endinterface

// File: rtl/spi_bist_misr.sv
// 8-bit multiple-input signature register; load reseeds, en folds one data byte in.
module spi_bist_misr
  import spi_bist_checker_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] signature
);

  logic [7:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = {sig_q[6:0], ^(sig_q & MisrTaps)} ^ data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign signature = sig_q;

endmodule

// File: rtl/spi_bist_checker.sv
// SPI loopback BIST run controller: sequences warm-up and scored frames, counts compare
// mismatches, captures the first failing frame and compacts received bytes into a MISR.
module spi_bist_checker
  import spi_bist_checker_pkg::*;
#(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned WARMUP_FRAMES = 1,
  parameter logic [7:0]  MISR_SEED     = 8'hFF
) (
  input logic               clk,
  input logic               reset,
  spi_bist_checker_if.slave bus
);

  // Only meaningful when WARMUP_FRAMES > 0; the warm-up state is unreachable otherwise.
  localparam logic [CNT_W-1:0] WarmLast = CNT_W'(WARMUP_FRAMES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] warm_cnt_q, warm_cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] mosi_err_q, mosi_err_d;
  logic [CNT_W-1:0] miso_err_q, miso_err_d;
  logic [CNT_W-1:0] first_fail_q, first_fail_d;
  logic             fail_valid_q, fail_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] frame_inc;
  logic             start_ok;
  logic             run_frame;

  assign frame_inc = frame_cnt_q + 1'b1;
  assign start_ok  = bus.start && !bus.abort && (state_q == StIdle || state_q == StDone);
  assign run_frame = bus.frame_done && !bus.abort && (state_q == StRun);

  always_comb begin
    state_d      = state_q;
    warm_cnt_d   = warm_cnt_q;
    num_d        = num_q;
    frame_cnt_d  = frame_cnt_q;
    mosi_err_d   = mosi_err_q;
    miso_err_d   = miso_err_q;
    first_fail_d = first_fail_q;
    fail_valid_d = fail_valid_q;

    if (bus.abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            num_d        = bus.num_frames;
            warm_cnt_d   = '0;
            frame_cnt_d  = '0;
            mosi_err_d   = '0;
            miso_err_d   = '0;
            first_fail_d = '0;
            fail_valid_d = 1'b0;
            if (bus.num_frames == '0) begin
              state_d = StDone;
            end else if (WARMUP_FRAMES > 0) begin
              state_d = StWarmup;
            end else begin
              state_d = StRun;
            end
          end
        end
        StWarmup: begin
          if (bus.frame_done) begin
            warm_cnt_d = warm_cnt_q + 1'b1;
            if (warm_cnt_q == WarmLast) begin
              state_d = StRun;
            end
          end
        end
        StRun: begin
          if (bus.frame_done) begin
            frame_cnt_d = frame_inc;
            if (!bus.mosi_res && mosi_err_q != '1) begin
              mosi_err_d = mosi_err_q + 1'b1;
            end
            if (!bus.miso_res && miso_err_q != '1) begin
              miso_err_d = miso_err_q + 1'b1;
            end
            if ((!bus.mosi_res || !bus.miso_res) && !fail_valid_q) begin
              fail_valid_d = 1'b1;
              first_fail_d = frame_cnt_q;
            end
            if (frame_inc == num_q) begin
              state_d = StDone;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Status flags are registered from the next state so they line up with the counters.
    busy_d = (state_d == StWarmup) || (state_d == StRun);
    done_d = (state_d == StDone);
    pass_d = done_d && (mosi_err_d == '0) && (miso_err_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      warm_cnt_q   <= '0;
      num_q        <= '0;
      frame_cnt_q  <= '0;
      mosi_err_q   <= '0;
      miso_err_q   <= '0;
      first_fail_q <= '0;
      fail_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      warm_cnt_q   <= warm_cnt_d;
      num_q        <= num_d;
      frame_cnt_q  <= frame_cnt_d;
      mosi_err_q   <= mosi_err_d;
      miso_err_q   <= miso_err_d;
      first_fail_q <= first_fail_d;
      fail_valid_q <= fail_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  spi_bist_misr #(
    .SEED (MISR_SEED)
  ) u_misr (
    .clk       (clk),
    .reset     (reset),
    .load      (start_ok),
    .en        (run_frame),
    .data      (bus.rx_byte),
    .signature (bus.signature)
  );

  assign bus.bist_select  = busy_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.frame_cnt    = frame_cnt_q;
  assign bus.mosi_err_cnt = mosi_err_q;
  assign bus.miso_err_cnt = miso_err_q;
  assign bus.fail_valid   = fail_valid_q;
  assign bus.first_fail   = first_fail_q;

endmodule

// File: tb/tb_spi_bist_checker.sv
// Directed bench for spi_bist_checker with hand-computed expectations.
module tb_spi_bist_checker;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  spi_bist_checker_if #(.CNT_W(16)) bus ();

  spi_bist_checker #(
    .CNT_W         (16),
    .WARMUP_FRAMES (1),
    .MISR_SEED     (8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] d);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ d;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [15:0] n);
    bus.start      = 1'b1;
    bus.num_frames = n;
    step(1);
    bus.start = 1'b0;
  endtask

  // One frame_done pulse; outputs are checked right after it, a gap follows separately.
  task automatic frame(input logic mosi, input logic miso, input logic [7:0] rx);
    bus.frame_done = 1'b1;
    bus.mosi_res   = mosi;
    bus.miso_res   = miso;
    bus.rx_byte    = rx;
    step(1);
    bus.frame_done = 1'b0;
    bus.mosi_res   = 1'b1;
    bus.miso_res   = 1'b1;
    bus.rx_byte    = 8'h00;
  endtask

  logic [7:0] sig_m;

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.num_frames = '0;
    bus.frame_done = 1'b0;
    bus.mosi_res   = 1'b1;
    bus.miso_res   = 1'b1;
    bus.rx_byte    = 8'h00;
    step(2);
    reset = 1'b1;
    step(1);

    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_bist", 32'(bus.bist_select), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_pass", 32'(bus.pass), 32'd0);
    check_val("rst_fvalid", 32'(bus.fail_valid), 32'd0);
    check_val("rst_fcnt", 32'(bus.frame_cnt), 32'd0);
    check_val("rst_errs", 32'({bus.mosi_err_cnt, bus.miso_err_cnt}), 32'd0);
    check_val("rst_ffail", 32'(bus.first_fail), 32'd0);
    check_val("rst_sig", 32'(bus.signature), 32'hFF);

    // Clean run: one warm-up frame then four scored zero bytes; FF->FE->FC->F8->F0.
    do_start(16'd4);
    check_val("t1_busy", 32'(bus.busy), 32'd1);
    check_val("t1_bist", 32'(bus.bist_select), 32'd1);
    frame(1'b0, 1'b0, 8'h5A);
    check_val("t1_warm_ignored", 32'({bus.frame_cnt, bus.mosi_err_cnt}), 32'd0);
    check_val("t1_warm_sig", 32'(bus.signature), 32'hFF);
    step(2);
    for (int i = 0; i < 4; i++) begin
      frame(1'b1, 1'b1, 8'h00);
      if (i < 3) begin
        check_val("t1_not_done", 32'({bus.done, bus.busy}), 32'b01);
        step(2);
      end
    end
    check_val("t1_done", 32'(bus.done), 32'd1);
    check_val("t1_pass", 32'(bus.pass), 32'd1);
    check_val("t1_fcnt", 32'(bus.frame_cnt), 32'd4);
    check_val("t1_errs", 32'({bus.mosi_err_cnt, bus.miso_err_cnt}), 32'd0);
    check_val("t1_bist", 32'({bus.bist_select, bus.busy}), 32'd0);
    check_val("t1_sig", 32'(bus.signature), 32'hF0);
    step(3);
    check_val("t1_frozen", 32'({bus.done, bus.frame_cnt}), {15'd0, 1'b1, 16'd4});

    // Six scored frames, MISO mismatch on frames 2 and 4, MOSI fail in warm-up only.
    do_start(16'd6);
    check_val("t2_cleared", 32'({bus.done, bus.frame_cnt}), 32'd0);
    check_val("t2_reseed", 32'(bus.signature), 32'hFF);
    frame(1'b0, 1'b1, 8'h11);
    step(2);
    sig_m = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] rx;
      rx    = 8'(i * 37 + 3);
      sig_m = misr_step(sig_m, rx);
      frame(1'b1, !(i == 2 || i == 4), rx);
      if (i == 2) begin
        check_val("t2_fvalid_at2", 32'(bus.fail_valid), 32'd1);
      end
      step(2);
    end
    check_val("t2_done", 32'(bus.done), 32'd1);
    check_val("t2_pass", 32'(bus.pass), 32'd0);
    check_val("t2_fcnt", 32'(bus.frame_cnt), 32'd6);
    check_val("t2_miso_err", 32'(bus.miso_err_cnt), 32'd2);
    check_val("t2_mosi_err", 32'(bus.mosi_err_cnt), 32'd0);
    check_val("t2_first_fail", 32'(bus.first_fail), 32'd2);
    check_val("t2_sig", 32'(bus.signature), 32'(sig_m));

    // Zero-length run: straight to done with pass, bist_select never set.
    do_start(16'd0);
    check_val("t3_done", 32'({bus.done, bus.pass}), 32'b11);
    check_val("t3_bist", 32'({bus.bist_select, bus.busy}), 32'd0);
    check_val("t3_cleared", 32'({bus.fail_valid, bus.miso_err_cnt}), 32'd0);
    frame(1'b0, 1'b0, 8'hAA);
    check_val("t3_ignore_fd", 32'({bus.frame_cnt, bus.mosi_err_cnt}), 32'd0);
    step(2);

    // Abort after two scored frames keeps diagnostics.
    do_start(16'd5);
    frame(1'b1, 1'b1, 8'h00);
    step(2);
    sig_m = misr_step(8'hFF, 8'h3C);
    frame(1'b1, 1'b1, 8'h3C);
    step(2);
    sig_m = misr_step(sig_m, 8'hC5);
    frame(1'b0, 1'b1, 8'hC5);
    step(2);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    check_val("t4_idle", 32'({bus.busy, bus.bist_select, bus.done}), 32'd0);
    check_val("t4_fcnt_kept", 32'(bus.frame_cnt), 32'd2);
    check_val("t4_err_kept", 32'(bus.mosi_err_cnt), 32'd1);
    check_val("t4_sig_kept", 32'(bus.signature), 32'(sig_m));
    frame(1'b0, 1'b0, 8'h77);
    check_val("t4_idle_fd", 32'({bus.frame_cnt, bus.mosi_err_cnt}), {16'd2, 16'd1});
    step(2);
    do_start(16'd3);
    check_val("t4_restart_fcnt", 32'(bus.frame_cnt), 32'd0);
    check_val("t4_restart_sig", 32'(bus.signature), 32'hFF);
    check_val("t4_restart_busy", 32'(bus.busy), 32'd1);

    // Start while busy is ignored; start together with abort aborts.
    frame(1'b1, 1'b1, 8'h00);
    step(2);
    frame(1'b1, 1'b1, 8'h00);
    step(2);
    do_start(16'd1);
    check_val("t5_start_ign", 32'({bus.busy, bus.frame_cnt}), {15'd0, 1'b1, 16'd1});
    frame(1'b1, 1'b1, 8'h00);
    check_val("t5_still_run", 32'({bus.done, bus.frame_cnt}), 32'd2);
    step(2);
    bus.abort = 1'b1;
    do_start(16'd4);
    bus.abort = 1'b0;
    check_val("t5_abort_wins", 32'({bus.busy, bus.done, bus.frame_cnt}), 32'd2);

    // Synchronous reset mid-run returns everything to reset values.
    do_start(16'd4);
    frame(1'b1, 1'b1, 8'h00);
    step(2);
    frame(1'b0, 1'b0, 8'h99);
    step(1);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    check_val("t6_rst_busy", 32'({bus.busy, bus.done, bus.fail_valid}), 32'd0);
    check_val("t6_rst_cnt", 32'({bus.frame_cnt, bus.miso_err_cnt}), 32'd0);
    check_val("t6_rst_sig", 32'(bus.signature), 32'hFF);
    step(1);
    check_val("t6_idle", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
